// File: rtl/vga_gen.sv
// VGA timing generator with grid, colour-bar, solid and streamed pixel sources.
// Sync, blank, colour and frame pulse are registered one cycle after the counter state.
module vga_gen #(
  parameter int   HDISP    = 800,
  parameter int   VDISP    = 480,
  parameter int   HFP      = 40,
  parameter int   HPULSE   = 48,
  parameter int   HBP      = 40,
  parameter int   VFP      = 13,
  parameter int   VPULSE   = 3,
  parameter int   VBP      = 29,
  parameter int   CW       = 8,
  parameter int   GRID     = 16,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic            pixel_clk,
  input  logic            pixel_rst,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] solid_rgb,
  input  logic [3*CW-1:0] pix_data,
  input  logic            pix_valid,
  input  logic            pix_sof,
  output logic            pix_ready,
  input  logic            err_clr,
  output logic            hs,
  output logic            vs,
  output logic            blank_n,
  output logic [3*CW-1:0] rgb,
  output logic            frame_start,
  output logic            underflow,
  output logic            desync,
  output logic            clk_out
);

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_S = HW'(HFP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_ACT_S  = HW'(HFP + HPULSE + HBP);
  localparam logic [VW-1:0] V_SYNC_S = VW'(VFP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_ACT_S  = VW'(VFP + VPULSE + VBP);
  localparam logic [HW+2:0] HDISP_W  = (HW+3)'(HDISP);
  localparam logic [31:0]   GRID_M   = 32'(GRID - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_ARMED, S_RUN} state_t;

  logic [HW-1:0]   h;
  logic [VW-1:0]   v;
  logic [1:0]      mode_q;
  state_t          state, state_next;
  logic            h_sync, v_sync, act, at_origin, frame_top, on_grid;
  logic [HW-1:0]   x;
  logic [VW-1:0]   y;
  logic [HW+2:0]   x8, bar_q;
  logic [2:0]      bar_idx;
  logic [3*CW-1:0] strm_rgb, rgb_next;
  logic            uf_set, ds_set;

  assign clk_out = pixel_clk;

  assign h_sync    = (h >= H_SYNC_S) && (h < H_SYNC_E);
  assign v_sync    = (v >= V_SYNC_S) && (v < V_SYNC_E);
  assign act       = (h >= H_ACT_S) && (v >= V_ACT_S);
  assign x         = h - H_ACT_S;
  assign y         = v - V_ACT_S;
  assign at_origin = act && (x == '0) && (y == '0);
  assign frame_top = (h == '0) && (v == '0);
  assign on_grid   = ((32'(x) & GRID_M) == 32'd0) || ((32'(y) & GRID_M) == 32'd0);
  assign x8        = {x, 3'b000};
  assign bar_q     = x8 / HDISP_W;
  assign bar_idx   = bar_q[2:0];

  // Raster counters and per-frame mode latch
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      h      <= '0;
      v      <= '0;
      mode_q <= 2'd0;
    end else begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      if (frame_top) begin
        mode_q <= mode;
      end
    end
  end

  // Stream FSM state register
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stream handshake and next state; a sof mismatch in RUN holds the beat and resynchronises
  always_comb begin
    state_next = state;
    pix_ready  = 1'b0;
    strm_rgb   = '0;
    uf_set     = 1'b0;
    ds_set     = 1'b0;
    case (state)
      S_IDLE: begin
        state_next = S_SEEK;
      end
      S_SEEK: begin
        pix_ready = !(pix_valid && pix_sof);
        if (pix_valid && pix_sof) begin
          state_next = S_ARMED;
        end else begin
          state_next = S_SEEK;
        end
      end
      S_ARMED: begin
        if (at_origin) begin
          pix_ready  = 1'b1;
          state_next = S_RUN;
          if (pix_valid) begin
            strm_rgb = pix_data;
          end else begin
            uf_set = 1'b1;
          end
        end else begin
          state_next = S_ARMED;
        end
      end
      S_RUN: begin
        if (act) begin
          if (pix_valid && (pix_sof != at_origin)) begin
            ds_set     = 1'b1;
            state_next = S_SEEK;
          end else begin
            pix_ready = 1'b1;
            if (pix_valid) begin
              strm_rgb = pix_data;
            end else begin
              uf_set = 1'b1;
            end
          end
        end else begin
          state_next = S_RUN;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (mode_q != 2'd3) begin
      state_next = S_IDLE;
    end else begin
      state_next = state_next;
    end
  end

  // Pixel colour selection by the frame-latched mode
  always_comb begin
    rgb_next = '0;
    if (act) begin
      case (mode_q)
        2'd0:    rgb_next = on_grid ? {(3*CW){1'b1}} : '0;
        2'd1:    rgb_next = {{CW{bar_idx[2]}}, {CW{bar_idx[1]}}, {CW{bar_idx[0]}}};
        2'd2:    rgb_next = solid_rgb;
        2'd3:    rgb_next = strm_rgb;
        default: rgb_next = '0;
      endcase
    end else begin
      rgb_next = '0;
    end
  end

  // Registered video outputs and sticky error flags (a set beats a same-cycle clear)
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hs          <= ~SYNC_POL;
      vs          <= ~SYNC_POL;
      blank_n     <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      desync      <= 1'b0;
    end else begin
      hs          <= h_sync ? SYNC_POL : ~SYNC_POL;
      vs          <= v_sync ? SYNC_POL : ~SYNC_POL;
      blank_n     <= act;
      rgb         <= rgb_next;
      frame_start <= frame_top;
      underflow   <= uf_set | (underflow & ~err_clr);
      desync      <= ds_set | (desync & ~err_clr);
    end
  end

endmodule

// File: doc/vga_gen.md
VGA_GEN -- requirements
Module: vga_gen

Interface
REQ-001 Parameters (name, default, meaning) SHALL be exactly:
- HDISP 800: active pixels per line.
- VDISP 480: active lines per frame.
- HFP 40, HPULSE 48, HBP 40: horizontal front porch, sync and back porch, in pixels.
- VFP 13, VPULSE 3, VBP 29: vertical front porch, sync and back porch, in lines.
- CW 8: bits per colour channel.
- GRID 16: grid pitch, power of two.
- SYNC_POL 0: active level of hs/vs.
REQ-002 Ports (name, direction, width, meaning) SHALL be exactly:
- pixel_clk in 1: pixel clock.
- pixel_rst in 1: reset, asynchronous, active-high.
- mode in 2: 0 grid, 1 colour bars, 2 solid, 3 stream.
- solid_rgb in 3*CW: colour for mode 2.
- pix_data in 3*CW: stream pixel, R in MSBs.
- pix_valid in 1: stream beat valid.
- pix_sof in 1: beat is first pixel of a frame.
- pix_ready out 1: stream beat accepted when valid&&ready.
- err_clr in 1: clears sticky flags.
- hs out 1: horizontal sync.
- vs out 1: vertical sync.
- blank_n out 1: high in active video.
- rgb out 3*CW: pixel colour.
- frame_start out 1: one-cycle pulse.
- underflow out 1: sticky flag.
- desync out 1: sticky flag.
- clk_out out 1: equals pixel_clk.

Function
REQ-003 Counters h (0..HTOTAL-1, HTOTAL=HFP+HPULSE+HBP+HDISP) and v (0..VTOTAL-1) SHALL behave as follows:
- h increments every cycle and wraps to 0 after HTOTAL-1.
- v increments on each h wrap and wraps to 0 after VTOTAL-1.
- Counter widths SHALL be $clog2(total).
REQ-004 Region order SHALL be front porch, sync, back porch, active. Horizontal sync SHALL be h in [HFP, HFP+HPULSE). Horizontal active SHALL be h >= HFP+HPULSE+HBP. Vertical regions SHALL be defined the same way from v.
REQ-005 Active pixel coordinates SHALL be x = h-(HFP+HPULSE+HBP) and y = v-(VFP+VPULSE+VBP), valid only when both are in range.
REQ-006 hs, vs, blank_n, rgb and frame_start SHALL be registered with 1-cycle latency from the counter state. hs SHALL equal SYNC_POL inside horizontal sync and ~SYNC_POL otherwise; vs likewise. blank_n SHALL be high only when h and v are both active.
REQ-007 rgb SHALL be all zero whenever the pixel is not active, in every mode.
REQ-008 Mode 0 (grid) SHALL output all-ones when x%GRID==0 or y%GRID==0, else zero.
REQ-009 Mode 1 (colour bars) SHALL use bar index = x*8/HDISP (0..7). Bits {R,G,B} = {idx[2],idx[1],idx[0]} each replicated to CW bits; idx 7 is white.
REQ-010 Mode 2 SHALL output solid_rgb, sampled every cycle.
REQ-011 mode SHALL be latched into mode_q only when h==0 and v==0. Changes mid-frame SHALL have no effect until the next frame.
REQ-012 frame_start SHALL pulse for 1 cycle on the output cycle corresponding to h==0, v==0.
REQ-013 The stream FSM SHALL have states IDLE, SEEK, ARMED and RUN:
- IDLE: pix_ready=0. Entered whenever mode_q!=3.
- SEEK: entered when mode_q becomes 3. pix_ready = !(pix_valid&&pix_sof), so non-SOF beats are discarded and the SOF beat is held, not consumed. On pix_valid&&pix_sof, go to ARMED.
- ARMED: pix_ready=0. On the first active pixel (x==0, y==0), go to RUN and consume that beat in the same cycle.
- RUN: pix_ready=1 exactly on active pixels.
REQ-014 In RUN, a consumed beat SHALL appear on rgb with 1-cycle latency. If pix_valid=0 on an active pixel, rgb SHALL be 0 that pixel, underflow SHALL be set, and the stream SHALL stay in RUN (no pixel skipped later).
REQ-015 In RUN, a beat with sof=1 at any position other than (0,0), or sof=0 at (0,0), SHALL set desync, the beat SHALL not be consumed, and the FSM SHALL go to SEEK. The rest of that frame SHALL output zero.
REQ-016 underflow and desync SHALL stay set until err_clr=1. If a set event and err_clr occur in the same cycle, set SHALL win.
REQ-017 A mode change out of 3 SHALL take effect only at a frame boundary, going to IDLE. A re-entry to mode 3 SHALL always restart from SEEK.
REQ-018 The block SHALL have no combinational path from pix_valid to rgb. pix_ready SHALL depend only on the FSM state, counters, pix_valid and pix_sof.

Reset
REQ-019 While pixel_rst=1, the block SHALL hold h=v=0, mode_q=0, FSM=IDLE, hs=vs=~SYNC_POL, blank_n=0, rgb=0, frame_start=0, underflow=0, desync=0, pix_ready=0.
REQ-020 Reset SHALL take effect asynchronously, at any point including mid-frame or mid-stream. Counting SHALL resume from h=0, v=0 on the first clock edge after release.

Verification
REQ-021 Defaults, mode 0, 2 frames: HTOTAL=928 and VTOTAL=525 measured. hs low for 48 cycles starting at h=40 (+1 latency). vs low for lines 13..15. blank_n high 384000 cycles per frame.
REQ-022 Mode 0: rgb=FFFFFF at x=0,16,32 and at y=0; rgb=000000 at (1,1) and (17,5); rgb=0 in all blanking.
REQ-023 Mode 1: x=0 gives 000000, x=100 gives 0000FF, x=799 gives FFFFFF. Switching mode to 2 mid-frame has no effect until the next frame_start.
REQ-024 Mode 3, source sends 3 junk beats then an SOF frame of incrementing data: the junk is dropped. rgb at (0,0) equals the SOF beat. 384000 beats are consumed per frame. underflow=0 and desync=0.
REQ-025 Mode 3, pix_valid low for 5 active pixels mid-line: those 5 pixels are 0, underflow=1 until err_clr, following pixels in order. Injected sof at (10,3): desync=1, zero output to frame end, relock on the next SOF.
REQ-026 pixel_rst pulsed mid-frame while in RUN: all outputs take their reset values immediately. After release, the FSM is IDLE and h=v=0.
